// File: rtl/cpu_pkg.sv
// Shared core definitions: default address/stack geometry and the
// next-PC source selector used by the sequencer datapath mux.
package cpu_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_TARGET = 2'd1,
    PC_POP    = 2'd2
  } pc_sel_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address LIFO. Drops pushes when full and pops when empty
// on its own, so the caller only has to decide what it wants to do.
module return_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int SP_W       = sp_width(STACK_DEPTH),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] entries [STACK_DEPTH];
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              do_push;
  logic              do_pop;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);

  // Depth is a power of two, so the low index bits of sp-1 are correct even
  // when sp == STACK_DEPTH (low bits 0 wrap to STACK_DEPTH-1).
  assign push_idx = sp[IDX_W-1:0];
  assign top_idx  = sp[IDX_W-1:0] - IDX_W'(1);
  assign top      = entries[top_idx];

  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end
  end

  // Entry storage carries no reset; contents survive pops and reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[push_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority next-PC selection (ret > call > jump >
// branch > increment), return-address stack and sticky stack error flags.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              ADDR_W      = DEF_ADDR_W,
  parameter int              STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        jump,
  input  logic                        branch,
  input  logic                        cond,
  input  logic                        call,
  input  logic                        ret,
  input  logic [ADDR_W-1:0]           target,
  input  logic                        clear_err,
  output logic [ADDR_W-1:0]           pc,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                        stack_overflow,
  output logic                        stack_underflow
);

  pc_sel_t           pc_sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              push_req;
  logic              pop_req;
  logic              ovf_event;
  logic              unf_event;

  assign pc_inc = pc + ADDR_W'(1);

  // Only the highest-priority strobe acts; multi-hot input is not an error.
  always_comb begin
    pc_sel    = PC_INC;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    ovf_event = 1'b0;
    unf_event = 1'b0;
    if (ret) begin
      if (!stk_empty) begin
        pc_sel  = PC_POP;
        pop_req = 1'b1;
      end else begin
        unf_event = 1'b1;
      end
    end else if (call) begin
      pc_sel = PC_TARGET;
      if (stk_full) begin
        ovf_event = 1'b1;
      end else begin
        push_req = 1'b1;
      end
    end else if (jump || (branch && cond)) begin
      pc_sel = PC_TARGET;
    end
  end

  always_comb begin
    next_pc = pc_inc;
    case (pc_sel)
      PC_TARGET: next_pc = target;
      PC_POP:    next_pc = stk_top;
      default:   next_pc = pc_inc;
    endcase
  end

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req && !stall),
    .pop       (pop_req && !stall),
    .push_data (pc_inc),
    .top       (stk_top),
    .sp        (sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // A same-cycle error event overrides clear_err for its own flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= RESET_PC;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      pc              <= next_pc;
      stack_overflow  <= ovf_event | (stack_overflow & ~clear_err);
      stack_underflow <= unf_event | (stack_underflow & ~clear_err);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, jump, branch, cond, call, ret, clear_err;
  logic [7:0] target;
  logic [7:0] pc;
  logic [3:0] sp;
  logic       stack_overflow, stack_underflow;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stack [$];
  bit         m_ovf, m_unf;

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(8), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .jump            (jump),
    .branch          (branch),
    .cond            (cond),
    .call            (call),
    .ret             (ret),
    .target          (target),
    .clear_err       (clear_err),
    .pc              (pc),
    .sp              (sp),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] nxt;
    bit ov, un;
    ov  = 1'b0;
    un  = 1'b0;
    nxt = m_pc + 8'd1;
    if (stall) return;
    if (ret) begin
      if (m_stack.size() > 0) nxt = m_stack.pop_back();
      else un = 1'b1;
    end else if (call) begin
      if (m_stack.size() < 8) m_stack.push_back(m_pc + 8'd1);
      else ov = 1'b1;
      nxt = target;
    end else if (jump) begin
      nxt = target;
    end else if (branch && cond) begin
      nxt = target;
    end
    if (clear_err) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (ov) m_ovf = 1'b1;
    if (un) m_unf = 1'b1;
    m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pc", int'(pc), int'(m_pc));
      chk("sp", int'(sp), m_stack.size());
      chk("overflow", int'(stack_overflow), int'(m_ovf));
      chk("underflow", int'(stack_underflow), int'(m_unf));
    end
  end

  task automatic drive(input bit s, input bit j, input bit b, input bit c,
                       input bit ca, input bit r, input logic [7:0] t,
                       input bit ce);
    stall = s; jump = j; branch = b; cond = c;
    call = ca; ret = r; target = t; clear_err = ce;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; jump = 0; branch = 0; cond = 0;
    call = 0; ret = 0; target = 8'h00; clear_err = 0;
    model_reset();
    #12;
    chk("reset_pc", int'(pc), 0);
    chk("reset_sp", int'(sp), 0);
    chk("reset_flags", int'({stack_overflow, stack_underflow}), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("idle_pc", int'(pc), i);
    end

    // Jump / branch
    drive(0, 1, 0, 0, 0, 0, 8'h10, 0);
    drive(0, 1, 0, 0, 0, 0, 8'h40, 0);
    chk("jump_pc", int'(pc), 'h40);
    drive(0, 0, 1, 0, 0, 0, 8'h80, 0);
    chk("branch_nt_pc", int'(pc), 'h41);
    drive(0, 0, 1, 1, 0, 0, 8'h80, 0);
    chk("branch_t_pc", int'(pc), 'h80);

    // Nested call / return
    drive(0, 1, 0, 0, 0, 0, 8'h05, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h20, 0);
    chk("call1_pc", int'(pc), 'h20);
    chk("call1_sp", int'(sp), 1);
    drive(0, 0, 0, 0, 1, 0, 8'h30, 0);
    chk("call2_pc", int'(pc), 'h30);
    chk("call2_sp", int'(sp), 2);
    drive(0, 0, 0, 0, 0, 1, 8'h00, 0);
    chk("ret1_pc", int'(pc), 'h21);
    chk("ret1_sp", int'(sp), 1);
    drive(0, 0, 0, 0, 0, 1, 8'h00, 0);
    chk("ret2_pc", int'(pc), 'h06);
    chk("ret2_sp", int'(sp), 0);

    // Overflow and underflow
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 1, 0, 8'h60 + 8'(i), 0);
    chk("ovf_sp", int'(sp), 8);
    chk("ovf_flag", int'(stack_overflow), 1);
    chk("ovf_pc", int'(pc), 'h68);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, 8'h00, 0);
    chk("unwind_pc", int'(pc), 'h07);
    chk("unwind_sp", int'(sp), 0);
    drive(0, 0, 0, 0, 0, 1, 8'h00, 0);
    chk("unf_pc", int'(pc), 'h08);
    chk("unf_flag", int'(stack_underflow), 1);
    drive(0, 0, 0, 0, 0, 0, 8'h00, 1);
    chk("clear_flags", int'({stack_overflow, stack_underflow}), 0);

    // Stall holds a pending call
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1, 0, 8'h90, 0);
    chk("stall_pc", int'(pc), 'h09);
    chk("stall_sp", int'(sp), 0);
    drive(0, 0, 0, 0, 1, 0, 8'h90, 0);
    chk("unstall_pc", int'(pc), 'h90);
    chk("unstall_sp", int'(sp), 1);
    idle();

    // PC wrap
    drive(0, 1, 0, 0, 0, 0, 8'hFF, 0);
    idle();
    chk("wrap_pc", int'(pc), 0);

    // Asynchronous reset mid-cycle with sp == 3
    drive(0, 0, 0, 0, 1, 0, 8'h33, 0);
    drive(0, 0, 0, 0, 1, 0, 8'h44, 0);
    chk("pre_reset_sp", int'(sp), 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_sp", int'(sp), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("post_reset_pc", int'(pc), 1);

    // Randomised traffic, including multi-hot strobes and stalls
    for (int i = 0; i < 3000; i++) begin
      bit s, j, b, c, ca, r, ce;
      int pick;
      s = ($urandom_range(0, 7) == 0);
      c = $urandom_range(0, 1);
      ce = ($urandom_range(0, 9) == 0);
      {j, b, ca, r} = 4'b0000;
      pick = $urandom_range(0, 15);
      case (pick)
        0, 1, 2:    ;
        3, 4:       j = 1'b1;
        5, 6, 7:    b = 1'b1;
        8, 9, 10:   ca = 1'b1;
        11, 12, 13: r = 1'b1;
        default:    {j, b, ca, r} = 4'($urandom_range(0, 15));
      endcase
      drive(s, j, b, c, ca, r, 8'($urandom_range(0, 255)), ce);
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle core. It sits directly downstream of the control unit and consumes its `jump`, `branch`, `call` and `ret` strobes plus a branch condition from the ALU. From these it produces the next instruction address each cycle. It contains a small hardware return-address stack for CALL/RET, with sticky overflow and underflow error flags.

## Interface
Parameters:
- `ADDR_W`, 8, width of the instruction address.
- `STACK_DEPTH`, 8, number of return-stack entries; must be a power of two and ≥2.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `stall`  in  1  high: hold PC, stack and flags unchanged.
- `jump`  in  1  from control unit: unconditional jump to `target`.
- `branch`  in  1  from control unit: conditional branch to `target`.
- `cond`  in  1  branch condition from ALU compare; BEQ/BNE polarity is already resolved upstream.
- `call`  in  1  from control unit: push return address, jump to `target`.
- `ret`  in  1  from control unit: pop return address into PC.
- `target`  in  ADDR_W  absolute target address from the instruction immediate.
- `clear_err`  in  1  synchronous clear of both error flags.
- `pc`  out  ADDR_W  current instruction address (registered).
- `sp`  out  $clog2(STACK_DEPTH)+1  current stack occupancy, 0..STACK_DEPTH.
- `stack_overflow`  out  1  sticky: a CALL was issued with the stack full.
- `stack_underflow`  out  1  sticky: a RET was issued with the stack empty.

## Operation
- `pc_inc` = `pc`+1, modulo 2^ADDR_W. 0xFF wraps to 0x00 at ADDR_W=8.
- Next-PC selection, in priority order; only the first active strobe acts:
  - `ret`: if `sp`>0, PC ← top entry and `sp`−1. If `sp`=0, PC ← `pc_inc`, stack unchanged, `stack_underflow` ← 1.
  - `call`: if `sp`<STACK_DEPTH, push `pc_inc` and `sp`+1. If full, the push is dropped and `stack_overflow` ← 1. PC ← `target` in both cases.
  - `jump`: PC ← `target`.
  - `branch` with `cond`=1: PC ← `target`. With `cond`=0: PC ← `pc_inc`.
  - no strobe active: PC ← `pc_inc`.
- The control unit normally drives at most one strobe per cycle. The priority order above only defines behaviour under illegal multi-hot input; no error is flagged for multi-hot.
- Stack organisation: LIFO, entries indexed 0..STACK_DEPTH−1. Push writes `entry[sp]`; pop reads `entry[sp−1]`. Entry contents persist after a pop and are not cleared.
- `stall`=1 freezes PC, `sp`, stack contents and flags, and has priority over all strobes. `clear_err` is also ignored while stalled.
- Error-flag update when `clear_err`=1 and not stalled:
  - Both flags clear.
  - An error event in the same cycle wins: set beats clear for that flag.

## Timing
- Reset (asynchronous, `rst_n`=0): `pc`=RESET_PC, `sp`=0, `stack_overflow`=0, `stack_underflow`=0. Stack entries are not reset.
- Release of `rst_n` is synchronised externally. The first PC update occurs on the first rising edge with `rst_n`=1.
- Latency is one cycle. Strobes sampled at edge N produce the new `pc` after edge N.
- The next-PC path from strobes, `cond` and `target` to the PC register is combinational.
- The top-of-stack read is combinational from the registered `sp`.
- A CALL followed immediately by a RET on the next cycle returns to call-site+1. No bypass is needed because the push completes at the edge.
- Reset asserted mid-operation, including during a stall, forces the reset values immediately.

## Structure
- Shared package `cpu_pkg` holds the default `ADDR_W` and `STACK_DEPTH`, plus an enum `pc_sel_t` with values {PC_INC, PC_TARGET, PC_POP}. The datapath mux uses this enum.
- Sub-module `return_stack`:
  - Parameterised by ADDR_W and STACK_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, sp, full, empty.
  - Handles its own overflow/underflow suppression.
- `pc_sequencer` instantiates `return_stack` and owns the PC register, the priority logic and the sticky flags.

## Test plan
- Reset then 4 idle cycles -> `pc` = 0,1,2,3,4; `sp`=0; both flags 0.
- At `pc`=0x10: `jump`, `target`=0x40 -> `pc`=0x40. Then `branch`, `cond`=0, `target`=0x80 -> `pc`=0x41. Then `branch`, `cond`=1 -> `pc`=0x80.
- CALL 0x20 from `pc`=0x05, then CALL 0x30 from 0x20 (nested), then RET, then RET -> `pc` sequence 0x20, 0x30, 0x21, 0x06; `sp` sequence 1, 2, 1, 0.
- Nine CALLs with STACK_DEPTH=8 -> `sp` saturates at 8 and `stack_overflow`=1 after the 9th. Then 8 RETs unwind correctly, and a 9th RET -> `pc`=`pc`+1 and `stack_underflow`=1. Then `clear_err` -> both flags 0.
- `stall`=1 for 3 cycles while `call` is asserted -> `pc` and `sp` unchanged. Deassert `stall` -> call executes once.
- `pc`=0xFF idle -> `pc`=0x00. Assert `rst_n`=0 asynchronously mid-cycle with `sp`=3 -> `pc`=RESET_PC and `sp`=0 immediately, before the next edge.
